spi_memory_master: RTL
======================

SPI_MEMORY_MASTER -- requirements
Module: spi_memory_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, SCK half-period in clk cycles (legal 1..255).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port _reset  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req  input  1  start request, sampled only when ready=1.
REQ-007 SHALL have port wr  input  1  1=write transaction, 0=read transaction.
REQ-008 SHALL have port addr  input  ADDR_WIDTH  target byte address.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port ready  output  1  idle, can accept req.
REQ-011 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  read data, valid from done until next read completes.
REQ-013 SHALL have port _select  output  1  SPI chip select, active low.
REQ-014 SHALL have port sck  output  1  SPI clock, idles low (mode 0).
REQ-015 SHALL have port mosi  output  1  serial data to responder.
REQ-016 SHALL have port miso  input  1  serial data from responder.

Function
REQ-017 SHALL implement states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-018 In IDLE with req=1, SHALL latch wr/addr/wdata into a 32-bit frame {opcode, addr[15:8], addr[7:0], payload} and enter SETUP next cycle.
REQ-019 Opcode SHALL be 8'h02 for write, 8'h03 for read; payload SHALL be wdata for write, 8'h00 for read.
REQ-020 Frame SHALL be sent MSB first; mosi SHALL present frame bit 31 in the first SETUP cycle.
REQ-021 _select SHALL be 0 in SETUP, SHIFT, HOLD and 1 in IDLE, GAP.
REQ-022 SETUP SHALL last CLK_DIV cycles with sck=0, then enter SHIFT.
REQ-023 SHIFT SHALL generate 32 sck periods, each CLK_DIV cycles high then CLK_DIV cycles low.
REQ-024 SHALL sample miso on the clk edge that drives sck 0->1; SHALL update mosi to the next bit on the edge that drives sck 1->0.
REQ-025 mosi SHALL stay stable while sck=1.
REQ-026 After the 32nd falling sck edge, HOLD SHALL last CLK_DIV cycles with sck=0, then enter GAP.
REQ-027 Total _select-low time SHALL be exactly 66*CLK_DIV cycles.
REQ-028 done SHALL be 1 for exactly the first GAP cycle.
REQ-029 For reads, rdata SHALL update to the last 8 sampled miso bits (MSB first) in the cycle done=1; writes SHALL leave rdata unchanged.
REQ-030 GAP SHALL last CLK_DIV cycles, then return to IDLE; ready SHALL be 1 only in IDLE.
REQ-031 req while ready=0 SHALL be ignored, not queued; wr/addr/wdata changes after acceptance SHALL not affect the frame.
REQ-032 req held high continuously SHALL start back-to-back transactions separated by CLK_DIV+1 cycles of _select=1.
REQ-033 Bit and divider counters SHALL wrap only via state transitions; no counter overflow SHALL alter sequencing.

Reset
REQ-034 With _reset=0 at a clk edge, next cycle SHALL give: state IDLE, ready=1, done=0, rdata=0, _select=1, sck=0, mosi=0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no done pulse; _select SHALL be 1 the next cycle.
REQ-036 Reset SHALL take priority over req in the same cycle.

Verification
REQ-037 CLK_DIV=2, write addr=16'h1234 wdata=8'hA5 -> mosi bytes 02 12 34 A5 at sck rises, _select low 132 cycles, one done pulse, rdata unchanged.
REQ-038 CLK_DIV=2, read addr=16'h00FF, responder model drives 8'h5C in last byte -> mosi 03 00 FF 00, rdata=8'h5C at done.
REQ-039 req pulsed during SHIFT -> ignored, exactly one transaction and one done pulse.
REQ-040 _reset=0 at SHIFT bit 10 -> next cycle _select=1, sck=0, ready=1, no done; subsequent write completes normally.
REQ-041 CLK_DIV=1, req held high for two transactions -> each _select low 66 cycles, high 2 cycles between, two done pulses.
REQ-042 Bench SHALL check mosi never changes while sck=1 and sck never toggles while _select=1, in all scenarios.

Source files
------------

// File: rtl/spi_memory_master.sv
// spi_memory_master: mode-0 SPI master issuing 32-bit read/write frames {opcode, addr, payload} to a serial memory
module spi_memory_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  _select,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic [4:0] bit_cnt;
  logic hi, rd, tick;
  logic [31:0] sh;
  logic [7:0] rx;
  logic [15:0] a16;
  assign a16 = 16'(addr);
  assign tick = cnt == 8'(CLK_DIV - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = req ? SETUP : IDLE;
      SETUP:   state_n = tick ? SHIFT : SETUP;
      SHIFT:   state_n = (tick && !hi && bit_cnt == 5'd31) ? HOLD : SHIFT;
      HOLD:    state_n = tick ? GAP : HOLD;
      GAP:     state_n = tick ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  assign ready   = state == IDLE;
  assign done    = state == GAP && cnt == 8'd0;
  assign _select = !(state inside {SETUP, SHIFT, HOLD});
  assign sck     = state == SHIFT && hi;
  assign mosi    = !_select && sh[31];
  always_ff @(posedge clk) begin
    if (!_reset) state <= IDLE;
    else state <= state_n;
  end
  // every phase ends on tick, so the divider restarts at each state change
  always_ff @(posedge clk) begin
    if (!_reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      hi      <= 1'b0;
      rd      <= 1'b0;
      sh      <= '0;
      rx      <= '0;
      rdata   <= '0;
    end else begin
      cnt <= (state == IDLE || tick) ? 8'd0 : cnt + 8'd1;
      if (state == IDLE && req) begin
        sh      <= {wr ? 8'h02 : 8'h03, a16, wr ? 8'(wdata) : 8'h00};
        rd      <= !wr;
        bit_cnt <= '0;
      end
      if (state == SETUP && tick) begin
        hi <= 1'b1;
        rx <= {rx[6:0], miso};
      end
      // hi->lo advances mosi; lo->hi samples miso unless the frame is finished
      if (state == SHIFT && tick) begin
        hi <= !hi;
        if (hi) sh <= {sh[30:0], 1'b0};
        else begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt != 5'd31) rx <= {rx[6:0], miso};
        end
      end
      if (state == HOLD && tick && rd) rdata <= DATA_WIDTH'(rx);
    end
  end
endmodule
